wormhole_switch_allocator: RTL
==============================

WORMHOLE_SWITCH_ALLOCATOR -- requirements
Module: wormhole_switch_allocator

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of input and output ports.
REQ-002 SHALL have parameter DEST_BITS, default 2, width of a port index, equal to log2(NUM_PORTS).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port req_valid, input, NUM_PORTS, input FIFO i is non-empty.
REQ-006 SHALL have port req_dest, input, NUM_PORTS*DEST_BITS, destination field of the front flit of input i (slice i).
REQ-007 SHALL have port req_head, input, NUM_PORTS, front flit of input i is a head flit.
REQ-008 SHALL have port req_tail, input, NUM_PORTS, front flit of input i is a tail flit; head plus tail marks a single-flit packet.
REQ-009 SHALL have port out_ready, input, NUM_PORTS, downstream of output o accepts a flit.
REQ-010 SHALL have port grant_rd, output, NUM_PORTS, pop strobe to input FIFO i.
REQ-011 SHALL have port out_sel, output, NUM_PORTS*DEST_BITS, index of the input owning output o (slice o), for the datapath mux.
REQ-012 SHALL have port out_valid, output, NUM_PORTS, output o presents a valid flit.
REQ-013 SHALL have port out_locked, output, NUM_PORTS, output o is in LOCKED.

Function
REQ-014 SHALL keep one FSM per output o, states IDLE and LOCKED, plus a registered owner[o] and a round-robin pointer rr_ptr[o].
REQ-015 In IDLE, candidates for output o SHALL be inputs with req_valid, req_head and req_dest == o that are not owned by any LOCKED output.
REQ-016 In IDLE with at least one candidate, the winner SHALL be the first candidate scanning from rr_ptr[o] upward, modulo NUM_PORTS.
REQ-017 On a win, the next cycle SHALL set state to LOCKED, owner[o] to the winner and rr_ptr[o] to winner+1 mod NUM_PORTS.
REQ-018 rr_ptr[o] SHALL change only on a win.
REQ-019 In LOCKED, out_valid[o] SHALL be req_valid[owner[o]], combinationally.
REQ-020 In LOCKED, grant_rd[owner[o]] SHALL be req_valid[owner[o]] AND out_ready[o], combinationally.
REQ-021 Head-to-first-transfer latency SHALL be 1 cycle.
REQ-022 A transfer with req_tail set SHALL return output o to IDLE on the next cycle.
REQ-023 Back-to-back packets on one output SHALL have exactly one idle bubble cycle between them.
REQ-024 In LOCKED with req_valid[owner] low (owner FIFO starved), the output SHALL stay LOCKED with out_valid 0 and no grant.
REQ-025 In LOCKED with out_ready low (backpressure), the output SHALL stay LOCKED and issue no grant; out_valid follows REQ-019.
REQ-026 In IDLE, out_valid[o] SHALL be 0 and no grant SHALL be issued from output o.
REQ-027 out_sel[o] SHALL equal owner[o] at all times; its value is don't-care in IDLE.
REQ-028 A non-head flit at the front of an unowned input SHALL be ignored and never granted.
REQ-029 A req_dest value >= NUM_PORTS SHALL match no output.
REQ-030 When several outputs win in the same cycle, all wins SHALL be independent; no input is granted by two outputs, guaranteed by REQ-015.
REQ-031 At most one grant_rd bit per input SHALL be asserted per cycle.

Reset
REQ-032 When rst_n is low at a clock edge, every FSM SHALL go to IDLE and all owner and rr_ptr registers SHALL clear to 0.
REQ-033 During and after reset, out_valid, grant_rd and out_locked SHALL be 0.
REQ-034 Reset mid-packet SHALL drop the lock immediately; a partially sent packet is not resumed.

Structure
REQ-035 Shared package router_pkg SHALL hold the default NUM_PORTS, DEST_BITS and the flit-type encoding constants (HEAD, BODY, TAIL, SINGLE).
REQ-036 SHALL instantiate one sub-module rr_arbiter per output: combinational round-robin pick from a request vector and a pointer; the FSM and registers stay in the parent.
REQ-037 Competent RTL size SHALL be 120-400 lines.

Verification
REQ-038 Single-flit packet: input 2 head+tail, dest 1, out_ready 1 -> out_locked[1] in cycle 1, grant_rd[2] and out_valid[1] in cycle 1, IDLE in cycle 2.
REQ-039 Contention: inputs 0 and 3 each send a 3-flit packet to dest 2 in cycle 0, rr_ptr 0 -> input 0 wins; input 3 is granted in cycle 5 with rr_ptr[2]=1; the packets do not interleave.
REQ-040 Fairness: inputs 0 and 1 continuously send single-flit packets to dest 0 -> grants alternate 0,1,0,1 with one bubble between packets.
REQ-041 Backpressure/starvation: 4-flit packet with out_ready low for cycles 2-4 and req_valid low in cycle 6 -> no grants in those cycles, state stays LOCKED, flit count is exactly 4.
REQ-042 Parallel and reset: inputs 0->3 and 1->2 run concurrently with both locked; rst_n low mid-packet -> all outputs 0 next cycle, rr_ptr 0.
REQ-043 Orphan body flit: req_valid with req_head 0 at an unowned input -> never granted.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: default port geometry, flit-type encoding and
// the per-output allocation state.
package router_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int DEST_BITS_DEF = 2;

  // Flit type as seen on the {head, tail} marker bits of a flit.
  typedef enum logic [1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HEAD   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  // Per-output allocation state.
  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_e;

  function automatic flit_type_e flit_type(input logic head, input logic tail);
    return flit_type_e'({head, tail});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from
// ptr, wrapping modulo N. Holds no state; the pointer lives in the parent.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_rot;

  // Rotate the request vector so that bit 0 is the request at ptr.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl >> ptr;
  end

  // Lowest set bit of the rotated vector, mapped back to an input index.
  always_comb begin
    int sum;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = 0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_valid && req_rot[k]) begin
        gnt_valid = 1'b1;
        sum       = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        gnt_idx   = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/wormhole_switch_allocator.sv
// Wormhole switch allocator. Each output port owns an IDLE/LOCKED FSM, an
// owner register (the input holding the output for the current packet) and
// a round-robin pointer. An output locks onto a head flit, forwards flits
// from its owner whenever the owner has data and downstream is ready, and
// releases on the transferred tail flit.
//
// Handshake: a flit moves from input i to output o in a cycle exactly when
// out_valid[o] and out_ready[o] are both high; grant_rd[i] is asserted in
// that same cycle and pops input FIFO i at the next rising edge. out_valid
// does not depend on out_ready.
module wormhole_switch_allocator
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DEST_BITS = DEST_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS*DEST_BITS-1:0] req_dest,
  input  logic [NUM_PORTS-1:0]           req_head,
  input  logic [NUM_PORTS-1:0]           req_tail,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS-1:0]           grant_rd,
  output logic [NUM_PORTS*DEST_BITS-1:0] out_sel,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [NUM_PORTS-1:0]           out_locked
);

  out_state_e           state_q [NUM_PORTS];
  logic [DEST_BITS-1:0] owner_q [NUM_PORTS];
  logic [DEST_BITS-1:0] rr_q    [NUM_PORTS];

  logic [NUM_PORTS-1:0] is_head;
  logic [NUM_PORTS-1:0] is_tail;
  logic [NUM_PORTS-1:0] locked;
  logic [NUM_PORTS-1:0] owned;
  logic [NUM_PORTS-1:0] cand [NUM_PORTS];
  logic [NUM_PORTS-1:0] win_valid;
  logic [DEST_BITS-1:0] win_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] own_valid;
  logic [NUM_PORTS-1:0] own_tail;
  logic [NUM_PORTS-1:0] xfer;

  function automatic logic [DEST_BITS-1:0] next_ptr(input logic [DEST_BITS-1:0] idx);
    if (idx == DEST_BITS'(NUM_PORTS - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // Decode the front-flit markers into head/tail qualifiers.
  always_comb begin
    is_head = '0;
    is_tail = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      is_head[i] = (flit_type(req_head[i], req_tail[i]) == HEAD) ||
                   (flit_type(req_head[i], req_tail[i]) == SINGLE);
      is_tail[i] = (flit_type(req_head[i], req_tail[i]) == TAIL) ||
                   (flit_type(req_head[i], req_tail[i]) == SINGLE);
    end
  end

  // Inputs currently held by some locked output; they may not start a new
  // packet elsewhere, which keeps simultaneous wins disjoint.
  always_comb begin
    owned = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      locked[o] = (state_q[o] == OUT_LOCKED);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (locked[o] && owner_q[o] == DEST_BITS'(i)) owned[i] = 1'b1;
      end
    end
  end

  // Head flits addressed to each output from inputs that are free.
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = req_valid[i] && is_head[i] && !owned[i] &&
                     (req_dest[i*DEST_BITS +: DEST_BITS] == DEST_BITS'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter #(
      .N     (NUM_PORTS),
      .IDX_W (DEST_BITS)
    ) u_rr_arbiter (
      .req       (cand[o]),
      .ptr       (rr_q[o]),
      .gnt_valid (win_valid[o]),
      .gnt_idx   (win_idx[o])
    );
  end

  // Owner-side view per output: owner's data presence, tail flag, transfer.
  always_comb begin
    own_valid = '0;
    own_tail  = '0;
    xfer      = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (owner_q[o] == DEST_BITS'(i)) begin
          own_valid[o] = req_valid[i];
          own_tail[o]  = is_tail[i];
        end
      end
      xfer[o] = locked[o] && own_valid[o] && out_ready[o];
    end
  end

  // Outputs; reset forces the strobes low even before the first edge.
  always_comb begin
    grant_rd   = '0;
    out_valid  = '0;
    out_locked = '0;
    out_sel    = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_sel[o*DEST_BITS +: DEST_BITS] = owner_q[o];
      out_locked[o] = rst_n && locked[o];
      out_valid[o]  = rst_n && locked[o] && own_valid[o];
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rst_n && xfer[o] && owner_q[o] == DEST_BITS'(i)) grant_rd[i] = 1'b1;
      end
    end
  end

  // Per-output FSM: lock on an arbitration win, release after the tail moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= OUT_IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        case (state_q[o])
          OUT_IDLE: begin
            if (win_valid[o]) begin
              state_q[o] <= OUT_LOCKED;
              owner_q[o] <= win_idx[o];
              rr_q[o]    <= next_ptr(win_idx[o]);
            end
          end
          OUT_LOCKED: begin
            if (xfer[o] && own_tail[o]) state_q[o] <= OUT_IDLE;
          end
          default: state_q[o] <= OUT_IDLE;
        endcase
      end
    end
  end

endmodule
